approx_sel_ctrl: RTL

Sequencing controller for the exact/approximate product select in one MAC lane of the DNN accelerator. Per layer it takes a configuration (operation count, window length, approximate ops per window) and, for each operand handshake, drives the 2:1 select between the exact and approximate multiplier products. It registers the selected product into a one-entry output stage with valid/ready backpressure, and reports layer completion plus an approximate-op count.

---
 rtl/approx_sel_ctrl_if.sv | 50 +++++
 rtl/approx_sel_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/approx_sel_ctrl_if.sv
// ----------------------------------------------------------------------------
// approx_sel_ctrl_if
// Bundles the handshake and status signals of one MAC-lane exact/approximate
// select controller.
//   cfg_*   : per-layer configuration handshake (ops, window M, approx N)
//   in_*    : operand product handshake (exact and approximate products)
//   sel     : 2:1 product select, 1 = exact, 0 = approximate
//   out_*   : one-entry registered output stage with valid/ready
//   busy, done, stat_apx : layer status and approximate-op statistic
// The master modport is the sequencing side (stimulus / upstream+downstream);
// the slave modport is the controller itself.
// ----------------------------------------------------------------------------
interface approx_sel_ctrl_if #(
    parameter int W     = 16,
    parameter int CNT_W = 16,
    parameter int WIN_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_ops;
    logic [WIN_W-1:0] cfg_win;
    logic [WIN_W-1:0] cfg_napx;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_exact;
    logic [W-1:0]     in_approx;
    logic             sel;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_approx;
    logic             out_last;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] stat_apx;

    modport master (
        output cfg_valid, cfg_ops, cfg_win, cfg_napx,
        output in_valid, in_exact, in_approx, out_ready,
        input  cfg_ready, in_ready, sel, out_valid, out_data,
        input  out_approx, out_last, busy, done, stat_apx
    );

    modport slave (
        input  cfg_valid, cfg_ops, cfg_win, cfg_napx,
        input  in_valid, in_exact, in_approx, out_ready,
        output cfg_ready, in_ready, sel, out_valid, out_data,
        output out_approx, out_last, busy, done, stat_apx
    );
endinterface

// File: rtl/approx_sel_ctrl.sv
// ----------------------------------------------------------------------------
// approx_sel_ctrl
// Sequences the exact/approximate product select for one MAC lane. A layer is
// configured with an op count, a window length M and N approximate ops per
// window; the first N ops of every window take the approximate product, the
// rest the exact one. Selected products go through a one-entry output
// register with valid/ready backpressure.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous reset, active-low
//   bus   : approx_sel_ctrl_if.slave (cfg, in, out handshakes and status)
// ----------------------------------------------------------------------------
module approx_sel_ctrl #(
    parameter int W     = 16,
    parameter int CNT_W = 16,
    parameter int WIN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    approx_sel_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q,      state_d;
    logic [WIN_W-1:0] win_q,        win_d;
    logic [WIN_W-1:0] napx_q,       napx_d;
    logic [WIN_W-1:0] pos_q,        pos_d;
    logic [CNT_W-1:0] rem_q,        rem_d;
    logic [CNT_W-1:0] stat_q,       stat_d;
    logic             out_valid_q,  out_valid_d;
    logic [W-1:0]     out_data_q,   out_data_d;
    logic             out_approx_q, out_approx_d;
    logic             out_last_q,   out_last_d;
    logic             done_q,       done_d;

    logic sel_s;
    logic cfg_ready_s;
    logic in_ready_s;
    logic cfg_acc_s;
    logic accept_s;
    logic out_hs_s;

    // Handshake qualifiers and the window-position based select.
    // With N >= M the position never reaches N, so every op is approximate.
    always_comb begin
        sel_s       = (pos_q >= napx_q) ? 1'b1 : 1'b0;
        cfg_ready_s = (state_q == ST_IDLE) ? 1'b1 : 1'b0;
        in_ready_s  = ((state_q == ST_RUN) && (!out_valid_q || bus.out_ready)) ? 1'b1 : 1'b0;
        cfg_acc_s   = bus.cfg_valid && cfg_ready_s;
        accept_s    = bus.in_valid && in_ready_s;
        out_hs_s    = out_valid_q && bus.out_ready;
    end

    // Next-state logic for the FSM, the datapath registers and the counters.
    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        napx_d       = napx_q;
        pos_d        = pos_q;
        rem_d        = rem_q;
        stat_d       = stat_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_approx_d = out_approx_q;
        out_last_d   = out_last_q;
        done_d       = 1'b0;

        // A drained entry empties the stage unless a new accept refills it.
        if (out_hs_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (accept_s) begin
            out_data_d   = sel_s ? bus.in_exact : bus.in_approx;
            out_approx_d = !sel_s;
            out_last_d   = (rem_q == CNT_W'(1)) ? 1'b1 : 1'b0;
            out_valid_d  = 1'b1;
            pos_d        = (pos_q == (win_q - WIN_W'(1))) ? {WIN_W{1'b0}} : (pos_q + WIN_W'(1));
            rem_d        = rem_q - CNT_W'(1);
            if (!sel_s && (stat_q != {CNT_W{1'b1}})) begin
                stat_d = stat_q + CNT_W'(1);
            end else begin
                stat_d = stat_q;
            end
        end else begin
            out_data_d = out_data_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_acc_s) begin
                    // A zero window length behaves as a window of one op.
                    win_d  = (bus.cfg_win == {WIN_W{1'b0}}) ? WIN_W'(1) : bus.cfg_win;
                    napx_d = bus.cfg_napx;
                    pos_d  = {WIN_W{1'b0}};
                    rem_d  = bus.cfg_ops;
                    stat_d = {CNT_W{1'b0}};
                    if (bus.cfg_ops == {CNT_W{1'b0}}) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && (rem_q == CNT_W'(1))) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (out_hs_s && out_last_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            win_q        <= WIN_W'(1);
            napx_q       <= {WIN_W{1'b0}};
            pos_q        <= {WIN_W{1'b0}};
            rem_q        <= {CNT_W{1'b0}};
            stat_q       <= {CNT_W{1'b0}};
            out_valid_q  <= 1'b0;
            out_data_q   <= {W{1'b0}};
            out_approx_q <= 1'b0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            napx_q       <= napx_d;
            pos_q        <= pos_d;
            rem_q        <= rem_d;
            stat_q       <= stat_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_approx_q <= out_approx_d;
            out_last_q   <= out_last_d;
            done_q       <= done_d;
        end
    end

    assign bus.cfg_ready  = cfg_ready_s;
    assign bus.in_ready   = in_ready_s;
    assign bus.sel        = sel_s;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_approx = out_approx_q;
    assign bus.out_last   = out_last_q;
    assign bus.busy       = (state_q != ST_IDLE) ? 1'b1 : 1'b0;
    assign bus.done       = done_q;
    assign bus.stat_apx   = stat_q;

endmodule
